// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data RAM plus LED, cycle counter and TX FIFO MMIO block.
// Define DMEM_ERR_EN to add a sticky error flag (STATUS bit8, err_o).
module dmem_responder #(
    parameter int          DEPTH_LOG2      = 12,
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [15:0] MMIO_BASE_HI    = 16'hBFD0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dm_addr_i,
    input  logic [3:0]  dm_wbe_n_i,
    input  logic [31:0] dm_wdata_i,
    input  logic        dm_re_i,
    input  logic        dm_we_i,
    output logic [31:0] dm_rdata_o,
    output logic [15:0] led_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i
`ifdef DMEM_ERR_EN
    ,
    output logic        err_o
`endif
);
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    logic [31:0] mem [2**DEPTH_LOG2];
    logic [7:0]  fifo [2**FIFO_DEPTH_LOG2];
    logic [FIFO_DEPTH_LOG2-1:0] rp, wp;
    logic [FIFO_DEPTH_LOG2:0]   fcnt;
    logic [DEPTH_LOG2-1:0]      idx;
    logic [31:0] cnt, sdata, wmask, status, mmio_rd;
    logic [15:0] off;
    logic is_mmio, wr, mmio_wr, is_b, is_h, empty, full, pop, push_req, push_ok, ovf, err_q;

    assign off     = dm_addr_i[15:0];
    assign idx     = dm_addr_i[DEPTH_LOG2+1:2];
    assign is_mmio = dm_addr_i[31:16] == MMIO_BASE_HI;
    assign wr      = dm_we_i && dm_wbe_n_i != 4'b1111;
    assign mmio_wr = wr && is_mmio;

    // Sub-word stores arrive in the low bits; replicate them so any lane can pick them up.
    assign is_b  = dm_wbe_n_i == 4'b1110 || dm_wbe_n_i == 4'b1101 ||
                   dm_wbe_n_i == 4'b1011 || dm_wbe_n_i == 4'b0111;
    assign is_h  = dm_wbe_n_i == 4'b1100 || dm_wbe_n_i == 4'b0011;
    assign sdata = is_b ? {4{dm_wdata_i[7:0]}} : is_h ? {2{dm_wdata_i[15:0]}} : dm_wdata_i;
    assign wmask = {{8{~dm_wbe_n_i[3]}}, {8{~dm_wbe_n_i[2]}}, {8{~dm_wbe_n_i[1]}}, {8{~dm_wbe_n_i[0]}}};

    assign empty      = fcnt == '0;
    assign full       = fcnt == FULL_CNT;
    assign pop        = !empty && tx_ready_i;
    assign push_req   = mmio_wr && off == 16'h0008;
    assign push_ok    = push_req && (!full || pop);
    assign tx_valid_o = !empty;
    assign tx_data_o  = empty ? 8'h00 : fifo[rp];

    assign status  = {23'd0, err_q, 4'(fcnt), 1'b0, ovf, full, empty};
    assign mmio_rd = off == 16'h0000 ? {16'h0000, led_o} :
                     off == 16'h0004 ? cnt :
                     off == 16'h000C ? status : 32'h0;
    assign dm_rdata_o = !dm_re_i ? 32'h0 : is_mmio ? mmio_rd : mem[idx];

    always_ff @(posedge clk)
        if (wr && !is_mmio)
            for (int i = 0; i < 4; i++)
                if (!dm_wbe_n_i[i]) mem[idx][8*i +: 8] <= sdata[8*i +: 8];

    always_ff @(posedge clk)
        if (push_ok) fifo[wp] <= sdata[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            led_o <= '0;
            cnt   <= '0;
            rp    <= '0;
            wp    <= '0;
            fcnt  <= '0;
            ovf   <= 1'b0;
        end else begin
            if (mmio_wr && off == 16'h0000)
                led_o <= (led_o & ~wmask[15:0]) | (sdata[15:0] & wmask[15:0]);
            cnt <= (mmio_wr && off == 16'h0004) ? (cnt & ~wmask) | (sdata & wmask) : cnt + 32'd1;
            if (pop) rp <= rp + (FIFO_DEPTH_LOG2)'(1);
            if (push_ok) wp <= wp + (FIFO_DEPTH_LOG2)'(1);
            if (push_ok != pop)
                fcnt <= push_ok ? fcnt + (FIFO_DEPTH_LOG2+1)'(1) : fcnt - (FIFO_DEPTH_LOG2+1)'(1);
            ovf <= (ovf && !(mmio_wr && off == 16'h000C && !dm_wbe_n_i[0] && sdata[2])) ||
                   (push_req && !push_ok);
        end
    end

`ifdef DMEM_ERR_EN
    logic bad_pat, unmapped;
    assign bad_pat  = wr && !is_b && !is_h && dm_wbe_n_i != 4'b0000;
    assign unmapped = is_mmio && (dm_re_i || wr) &&
                      !(off == 16'h0000 || off == 16'h0004 || off == 16'h0008 || off == 16'h000C);
    always_ff @(posedge clk)
        if (rst) err_q <= 1'b0;
        else err_q <= (err_q && !(mmio_wr && off == 16'h000C && !dm_wbe_n_i[1] && sdata[8])) ||
                      bad_pat || unmapped || (is_mmio && dm_re_i && off == 16'h0008);
    assign err_o = err_q;
`else
    assign err_q = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of RAM steering, counter, TX FIFO, STATUS and optional err flag.
module tb_dmem_responder;
    logic        clk = 0, rst = 1;
    logic [31:0] dm_addr_i = 0, dm_wdata_i = 0, dm_rdata_o;
    logic [3:0]  dm_wbe_n_i = 4'hF;
    logic        dm_re_i = 0, dm_we_i = 0, tx_valid_o, tx_ready_i = 0;
    logic [15:0] led_o;
    logic [7:0]  tx_data_o;
`ifdef DMEM_ERR_EN
    logic        err_o;
`endif
    int vectors = 0, miscompares = 0;
    logic [31:0] r;

    localparam logic [31:0] LED = 32'hBFD0_0000, CNT = 32'hBFD0_0004,
                            TXD = 32'hBFD0_0008, STS = 32'hBFD0_000C;

    dmem_responder dut (
        .clk(clk), .rst(rst), .dm_addr_i(dm_addr_i), .dm_wbe_n_i(dm_wbe_n_i),
        .dm_wdata_i(dm_wdata_i), .dm_re_i(dm_re_i), .dm_we_i(dm_we_i),
        .dm_rdata_o(dm_rdata_o), .led_o(led_o), .tx_valid_o(tx_valid_o),
        .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i)
`ifdef DMEM_ERR_EN
        , .err_o(err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        dm_addr_i = a; dm_wbe_n_i = be; dm_wdata_i = d; dm_we_i = 1; dm_re_i = 0;
        @(posedge clk); #1;
        dm_we_i = 0; dm_wbe_n_i = 4'hF;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        dm_addr_i = a; dm_re_i = 1;
        #1 d = dm_rdata_o;
        dm_re_i = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_led", {16'h0, led_o}, 32'h0);
        chk("rst_txv", {31'h0, tx_valid_o}, 32'h0);
        chk("rst_txd", {24'h0, tx_data_o}, 32'h0);
        rd(STS, r); chk("rst_status", r, 32'h0000_0001);
        rd(CNT, r); chk("cnt0", r, 32'h0);
        repeat (5) @(posedge clk);
        #1 rd(CNT, r); chk("cnt5", r, 32'd5);
        wr(CNT, 4'b0000, 32'hFFFF_FFFE);
        rd(CNT, r); chk("cnt_load", r, 32'hFFFF_FFFE);
        @(posedge clk); #1 rd(CNT, r); chk("cnt_inc", r, 32'hFFFF_FFFF);
        @(posedge clk); #1 rd(CNT, r); chk("cnt_wrap", r, 32'h0);

        wr(32'h100, 4'b0000, 32'h1122_3344);
        wr(32'h101, 4'b1101, 32'h0000_00AB);
        rd(32'h101, r); chk("sb", r, 32'h1122_AB44);
        rd(32'h4100, r); chk("alias", r, 32'h1122_AB44);
        dm_addr_i = 32'h100; #1 chk("re_low", dm_rdata_o, 32'h0);
        wr(32'h0, 4'b0000, 32'h0);
        wr(32'h2, 4'b0011, 32'h0000_BEEF);
        rd(32'h0, r); chk("sh", r, 32'hBEEF_0000);
        wr(32'h0, 4'b1111, 32'h1234_5678);
        rd(32'h0, r); chk("wbe_masked", r, 32'hBEEF_0000);
        dm_addr_i = 32'h0; dm_wbe_n_i = 4'b0000; dm_wdata_i = 32'hCAFE_F00D; dm_we_i = 1; dm_re_i = 1;
        #1 chk("rd_pre_edge", dm_rdata_o, 32'hBEEF_0000);
        @(posedge clk); #1 chk("rd_post_edge", dm_rdata_o, 32'hCAFE_F00D);
        dm_we_i = 0; dm_re_i = 0; dm_wbe_n_i = 4'hF;
        rd(32'h0001_0000, r); chk("not_mmio", r, 32'hCAFE_F00D);

        wr(LED, 4'b0000, 32'hDEAD_1234);
        chk("led_word", {16'h0, led_o}, 32'h0000_1234);
        wr(LED, 4'b1110, 32'h0000_00AB);
        rd(LED, r); chk("led_byte", r, 32'h0000_12AB);

        for (int i = 1; i <= 9; i++) wr(TXD, 4'b1110, i);
        rd(STS, r); chk("fifo_full", r, 32'h0000_0086);
        rd(TXD, r); chk("txdata_rd", r, 32'h0);
        tx_ready_i = 1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_v", {31'h0, tx_valid_o}, 32'h1);
            chk("drain_d", {24'h0, tx_data_o}, i);
            @(posedge clk); #1;
        end
        chk("drained_v", {31'h0, tx_valid_o}, 32'h0);
        rd(STS, r); chk("drained_sts", r, 32'h0000_0005);
        wr(STS, 4'b1110, 32'h0000_0004);
        rd(STS, r); chk("ovf_w1c", r, 32'h0000_0001);

        tx_ready_i = 0;
        for (int i = 0; i < 8; i++) wr(TXD, 4'b1110, 32'h10 + i);
        rd(STS, r); chk("refill", r, 32'h0000_0082);
        tx_ready_i = 1;
        wr(TXD, 4'b1110, 32'h18);
        rd(STS, r); chk("push_pop_full", r, 32'h0000_0082);
        chk("push_pop_head", {24'h0, tx_data_o}, 32'h11);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_mid_v", {31'h0, tx_valid_o}, 32'h0);
        rd(STS, r); chk("rst_mid_sts", r, 32'h0000_0001);
        chk("rst_mid_led", {16'h0, led_o}, 32'h0);
        rst = 0; tx_ready_i = 0;

        wr(32'h200, 4'b0000, 32'hFFFF_FFFF);
        wr(32'h200, 4'b1010, 32'h1122_3344);
        rd(32'h200, r); chk("odd_pattern", r, 32'hFF22_FF44);
`ifdef DMEM_ERR_EN
        chk("err_set", {31'h0, err_o}, 32'h1);
        rd(STS, r); chk("err_sts", r, 32'h0000_0101);
        wr(STS, 4'b0000, 32'h0000_0100);
        chk("err_clr", {31'h0, err_o}, 32'h0);
        rd(STS, r); chk("err_clr_sts", r, 32'h0000_0001);
        wr(32'hBFD0_0010, 4'b0000, 32'h5555_5555);
        rd(STS, r); chk("err_unmapped", r, 32'h0000_0101);
`else
        rd(STS, r); chk("no_err_sts", r, 32'h0000_0001);
        wr(32'hBFD0_0010, 4'b0000, 32'h5555_5555);
        rd(STS, r); chk("unmapped_sts", r, 32'h0000_0001);
`endif
        rd(32'hBFD0_0010, r); chk("unmapped_rd", r, 32'h0);
        rd(LED, r); chk("led_after_rst", r, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
